// File: rtl/dff_ctrl_pkg.sv
// Shared types for the flop-bank controller: opcodes, FSM states, command payload
// and the expected-bank-state helper used for the integrity check.
package dff_ctrl_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_PRESET = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_READ   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        APPLY = 2'b01,
        CHECK = 2'b10
    } state_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] data;
        logic             id;
    } cmd_t;

    // Bank state a healthy bank must hold after the command is applied
    function automatic logic [WIDTH-1:0] expected_q(input op_e op,
                                                    input logic [WIDTH-1:0] data,
                                                    input logic [WIDTH-1:0] q_prev);
        logic [WIDTH-1:0] res;
        case (op)
            OP_LOAD:   res = data;
            OP_PRESET: res = q_prev | data;
            OP_CLEAR:  res = q_prev & ~data;
            default:   res = q_prev;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/arb2_rr.sv
// Two-requester round-robin arbiter; the last winner loses the next tie.
module arb2_rr (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic last_grant;

    always_comb begin
        grant_c = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
                default: grant_c = 2'b00;
            endcase
        end
    end

    // Reset to 1 so requester 0 takes the first tie
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_c[1];
        end
    end

endmodule

// File: rtl/dff_bank_ctrl.sv
// Shares one external flop bank between two requesters: accept, apply one
// control set for a cycle, then read the bank back and flag any mismatch.
module dff_bank_ctrl
    import dff_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             load_o,
    output logic [WIDTH-1:0] d_o,
    output logic [WIDTH-1:0] pre_o,
    output logic [WIDTH-1:0] clr_o,
    input  logic [WIDTH-1:0] q_i,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_q,
    output logic             resp_err
);

    state_e           state, state_d;
    cmd_t             cmd_q, cmd_d, cmd_sel;
    logic [WIDTH-1:0] q_prev, q_prev_d;
    logic             load_d, resp_valid_d, resp_id_d;
    logic [WIDTH-1:0] d_d, pre_d, clr_d;
    logic [1:0]       valid, grant;
    logic             arb_en, accept;

    assign valid  = {req1_valid, req0_valid};
    assign arb_en = (state == IDLE) && clr_n;
    assign accept = |(grant & valid);

    arb2_rr u_arb (
        .clk     (clk),
        .clr_n   (clr_n),
        .valid   (valid),
        .en      (arb_en),
        .accept  (accept),
        .grant_c (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        cmd_sel.id   = grant[1];
        cmd_sel.op   = op_e'(grant[1] ? req1_op : req0_op);
        cmd_sel.data = grant[1] ? req1_data : req0_data;
    end

    always_comb begin
        state_d      = state;
        cmd_d        = cmd_q;
        q_prev_d     = q_prev;
        load_d       = 1'b0;
        d_d          = '0;
        pre_d        = '0;
        clr_d        = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d  = APPLY;
                    cmd_d    = cmd_sel;
                    q_prev_d = q_i;
                    case (cmd_sel.op)
                        OP_LOAD: begin
                            load_d = 1'b1;
                            d_d    = cmd_sel.data;
                        end
                        OP_PRESET: pre_d = cmd_sel.data;
                        OP_CLEAR:  clr_d = cmd_sel.data;
                        default: ;
                    endcase
                end
            end
            APPLY: begin
                state_d      = CHECK;
                resp_valid_d = 1'b1;
                resp_id_d    = cmd_q.id;
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cmd_q      <= '0;
            q_prev     <= '0;
            load_o     <= 1'b0;
            d_o        <= '0;
            pre_o      <= '0;
            clr_o      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            q_prev     <= q_prev_d;
            load_o     <= load_d;
            d_o        <= d_d;
            pre_o      <= pre_d;
            clr_o      <= clr_d;
            resp_valid <= resp_valid_d;
            resp_id    <= resp_id_d;
        end
    end

    // The bank settles on the edge that enters CHECK, so readback is observed live
    assign resp_q   = resp_valid ? q_i : '0;
    assign resp_err = resp_valid && (q_i != expected_q(cmd_q.op, cmd_q.data, q_prev));

endmodule

// File: tb/tb_dff_bank_ctrl.sv
// Bench for dff_bank_ctrl: behavioural flop bank, vector table plus corner-case
// sequences, responses checked against a scoreboard queue.
module tb_dff_bank_ctrl;
    import dff_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       load_o;
    logic [7:0] d_o, pre_o, clr_o;
    logic [7:0] bank_q = 8'h00;
    logic       fault = 1'b0;
    logic       resp_valid, resp_id, resp_err;
    logic [7:0] resp_q;

    always #5 clk = ~clk;

    dff_bank_ctrl dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .load_o     (load_o),
        .d_o        (d_o),
        .pre_o      (pre_o),
        .clr_o      (clr_o),
        .q_i        (bank_q),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_q     (resp_q),
        .resp_err   (resp_err)
    );

    // Behavioural bank; fault makes it ignore load
    always @(posedge clk) begin
        logic [7:0] nq;
        nq = (load_o && !fault) ? d_o : bank_q;
        bank_q <= (nq | pre_o) & ~clr_o;
    end

    typedef struct {
        logic       id;
        logic [7:0] q;
        logic       err;
    } exp_t;

    typedef struct {
        logic       id;
        op_e        op;
        logic [7:0] data;
        logic       fault;
        logic [7:0] exp_q;
        logic       exp_err;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[11];
    int   n_chk = 0, n_pass = 0;
    int   resp_cnt = 0, acc0 = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc++;
    always @(negedge clk) if (req0_valid && req0_ready) acc0++;

    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", 32'(resp_id), 32'(e.id));
                    check("resp_q", 32'(resp_q), 32'(e.q));
                    check("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic set_req(input logic id, input logic v, input logic [1:0] op, input logic [7:0] data);
        if (id == 1'b0) begin
            req0_valid = v; req0_op = op; req0_data = data;
        end else begin
            req1_valid = v; req1_op = op; req1_data = data;
        end
    endtask

    // Returns at the negedge of the accept cycle
    task automatic wait_ready(output logic got, output logic ok);
        got = 1'b0;
        ok  = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin
                got = 1'b0; ok = 1'b1; return;
            end
            if (req1_valid && req1_ready) begin
                got = 1'b1; ok = 1'b1; return;
            end
        end
    endtask

    task automatic do_cmd(input logic id, input op_e op, input logic [7:0] data,
                          input logic [7:0] exp_q, input logic exp_err);
        logic got, ok;
        set_req(id, 1'b1, op, data);
        wait_ready(got, ok);
        check("accept_timeout", 32'(ok), 32'd1);
        if (!ok) begin
            set_req(id, 1'b0, 2'b00, 8'h00);
            return;
        end
        check("accept_id", 32'(got), 32'(id));
        sb.push_back('{id, exp_q, exp_err});
        @(posedge clk); #1;
        set_req(id, 1'b0, 2'b00, 8'h00);
        @(negedge clk);
        check("apply_load", 32'(load_o), 32'(op == OP_LOAD));
        check("apply_d", 32'(d_o), (op == OP_LOAD) ? 32'(data) : 32'd0);
        check("apply_pre", 32'(pre_o), (op == OP_PRESET) ? 32'(data) : 32'd0);
        check("apply_clr", 32'(clr_o), (op == OP_CLEAR) ? 32'(data) : 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_load"}, 32'(load_o), 32'd0);
        check({tag, "_d"}, 32'(d_o), 32'd0);
        check({tag, "_pre"}, 32'(pre_o), 32'd0);
        check({tag, "_clr"}, 32'(clr_o), 32'd0);
        check({tag, "_resp"}, {29'd0, resp_valid, resp_id, resp_err}, 32'd0);
        check({tag, "_resp_q"}, 32'(resp_q), 32'd0);
        check({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got, ok;
        logic exp_order[3];
        int   acc_cyc[3];
        int   a0, rc;

        vecs[0]  = '{1'b0, OP_LOAD,   8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1]  = '{1'b1, OP_PRESET, 8'h0F, 1'b0, 8'hAF, 1'b0};
        vecs[2]  = '{1'b1, OP_CLEAR,  8'hA0, 1'b0, 8'h0F, 1'b0};
        vecs[3]  = '{1'b0, OP_LOAD,   8'h5A, 1'b0, 8'h5A, 1'b0};
        vecs[4]  = '{1'b1, OP_READ,   8'hFF, 1'b0, 8'h5A, 1'b0};
        vecs[5]  = '{1'b0, OP_PRESET, 8'h00, 1'b0, 8'h5A, 1'b0};
        vecs[6]  = '{1'b1, OP_CLEAR,  8'h00, 1'b0, 8'h5A, 1'b0};
        vecs[7]  = '{1'b0, OP_PRESET, 8'h81, 1'b0, 8'hDB, 1'b0};
        vecs[8]  = '{1'b1, OP_CLEAR,  8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, OP_LOAD,   8'h3C, 1'b1, 8'h00, 1'b1};
        vecs[10] = '{1'b1, OP_READ,   8'h00, 1'b0, 8'h00, 1'b0};
        exp_order = '{1'b0, 1'b1, 1'b0};

        // Reset with both requesters valid: nothing may be ready
        #2 clr_n = 1'b0;
        set_req(1'b0, 1'b1, OP_LOAD, 8'hFF);
        set_req(1'b1, 1'b1, OP_LOAD, 8'hFF);
        repeat (2) @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 2'b00, 8'h00);
        set_req(1'b1, 1'b0, 2'b00, 8'h00);
        clr_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            fault = vecs[i].fault;
            do_cmd(vecs[i].id, vecs[i].op, vecs[i].data, vecs[i].exp_q, vecs[i].exp_err);
            fault = 1'b0;
        end

        // Withdraw: req0 raises then drops valid while req1's command is in APPLY
        do_cmd(1'b1, OP_LOAD, 8'h96, 8'h96, 1'b0);
        set_req(1'b1, 1'b1, OP_PRESET, 8'h01);
        wait_ready(got, ok);
        check("wd_accept", {30'd0, ok, got}, 32'd3);
        sb.push_back('{1'b1, 8'h97, 1'b0});
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 2'b00, 8'h00);
        set_req(1'b0, 1'b1, OP_LOAD, 8'hFF);
        a0 = acc0;
        @(negedge clk);
        check("wd_ready_apply", 32'(req0_ready), 32'd0);
        check("wd_pre", 32'(pre_o), 32'h01);
        #1 set_req(1'b0, 1'b0, 2'b00, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        check("wd_no_accept", 32'(acc0 - a0), 32'd0);
        check("wd_bank", 32'(bank_q), 32'h97);

        // Tie after reset: grants alternate 0,1,0 at 3-cycle spacing
        #1 clr_n = 1'b0;
        @(negedge clk);
        reset_checks("reset2");
        @(posedge clk); #1;
        clr_n = 1'b1;
        set_req(1'b0, 1'b1, OP_LOAD, 8'h11);
        set_req(1'b1, 1'b1, OP_LOAD, 8'h22);
        for (int i = 0; i < 3; i++) begin
            wait_ready(got, ok);
            check("tie_accept", 32'(ok), 32'd1);
            check("tie_order", 32'(got), 32'(exp_order[i]));
            acc_cyc[i] = cyc;
            sb.push_back('{exp_order[i], exp_order[i] ? 8'h22 : 8'h11, 1'b0});
            if (i > 0) check("tie_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
            @(posedge clk); #1;
        end
        set_req(1'b0, 1'b0, 2'b00, 8'h00);
        set_req(1'b1, 1'b0, 2'b00, 8'h00);
        repeat (3) @(posedge clk);
        #1;

        // Reset during APPLY abandons the command
        set_req(1'b0, 1'b1, OP_LOAD, 8'h77);
        wait_ready(got, ok);
        check("mid_accept", {30'd0, ok, got}, 32'd2);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 2'b00, 8'h00);
        @(negedge clk);
        check("mid_load_before", 32'(load_o), 32'd1);
        rc = resp_cnt;
        #1 clr_n = 1'b0;
        #1;
        check("mid_load_drop", 32'(load_o), 32'd0);
        check("mid_d_drop", 32'(d_o), 32'd0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        set_req(1'b0, 1'b1, OP_LOAD, 8'h44);
        set_req(1'b1, 1'b1, OP_LOAD, 8'h55);
        @(negedge clk);
        check("mid_no_resp", 32'(resp_valid), 32'd0);
        check("mid_bank_kept", 32'(bank_q), 32'h11);
        check("mid_tie_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        if (req0_ready) sb.push_back('{1'b0, 8'h44, 1'b0});
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 2'b00, 8'h00);
        set_req(1'b1, 1'b0, 2'b00, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        check("mid_resp_count", 32'(resp_cnt - rc), 32'd1);
        check("mid_bank_final", 32'(bank_q), 32'h44);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
